// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : RISC-V MEM stage, byte-serial little-endian load/store engine
// Revision  : 1.0
// ============================================================================
`default_nettype none

`ifndef MEM_STAGE_OP_DEFINES
`define MEM_STAGE_OP_DEFINES
`define AluOpBus  7:0
`define EX_NOP_OP 8'h00
`define EX_LB_OP  8'h20
`define EX_LH_OP  8'h21
`define EX_LW_OP  8'h22
`define EX_LBU_OP 8'h23
`define EX_LHU_OP 8'h24
`define EX_SB_OP  8'h25
`define EX_SH_OP  8'h26
`define EX_SW_OP  8'h27
`endif

module mem_stage (
  input  logic             clk,
  input  logic             rst,
  input  logic [`AluOpBus] aluop_i,
  input  logic [31:0]      ram_addr_i,
  input  logic [31:0]      store_data_i,
  input  logic             w_enable_i,
  input  logic [4:0]       w_addr_i,
  input  logic [31:0]      w_data_i,
  input  logic             pipe_adv_i,
  output logic             mem_req_o,
  output logic             mem_wr_o,
  output logic [31:0]      mem_addr_o,
  output logic [7:0]       mem_wdata_o,
  input  logic [7:0]       mem_rdata_i,
  input  logic             mem_ack_i,
  output logic             w_enable_o,
  output logic [4:0]       w_addr_o,
  output logic [31:0]      w_data_o,
  output logic             mem_stall_req_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic [`AluOpBus] op_q, op_d;
  logic [31:0]      sdata_q, sdata_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_wr_q, mem_wr_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]       cnt_next;
  logic [31:0]      ext_data;

  function automatic logic is_mem_op(input logic [`AluOpBus] op);
    case (op)
      `EX_LB_OP, `EX_LH_OP, `EX_LW_OP, `EX_LBU_OP, `EX_LHU_OP,
      `EX_SB_OP, `EX_SH_OP, `EX_SW_OP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [`AluOpBus] op);
    return (op == `EX_SB_OP) || (op == `EX_SH_OP) || (op == `EX_SW_OP);
  endfunction

  // Index of the final byte of the access (byte count minus one).
  function automatic logic [1:0] last_idx(input logic [`AluOpBus] op);
    case (op)
      `EX_LH_OP, `EX_LHU_OP, `EX_SH_OP: return 2'd1;
      `EX_LW_OP, `EX_SW_OP:             return 2'd3;
      default:                          return 2'd0;
    endcase
  endfunction

  assign cnt_next = cnt_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    op_d        = op_q;
    sdata_d     = sdata_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem_op(aluop_i)) begin
          state_d     = S_ACCESS;
          op_d        = aluop_i;
          sdata_d     = store_data_i;
          cnt_d       = 2'd0;
          result_d    = 32'd0;
          mem_req_d   = 1'b1;
          mem_wr_d    = is_store(aluop_i);
          mem_addr_d  = ram_addr_i;
          mem_wdata_d = store_data_i[7:0];
        end
      end
      S_ACCESS: begin
        if (mem_req_q && mem_ack_i) begin
          if (!is_store(op_q)) begin
            result_d[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
          end
          if (cnt_q == last_idx(op_q)) begin
            // Request drops on the edge that takes the final ack.
            mem_req_d = 1'b0;
            mem_wr_d  = 1'b0;
            state_d   = S_DONE;
          end else begin
            cnt_d       = cnt_next;
            mem_addr_d  = mem_addr_q + 32'd1;
            mem_wdata_d = sdata_q[{cnt_next, 3'b000} +: 8];
          end
        end
      end
      S_DONE: begin
        if (pipe_adv_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      result_q    <= 32'd0;
      op_q        <= `EX_NOP_OP;
      sdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      op_q        <= op_d;
      sdata_q     <= sdata_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    case (op_q)
      `EX_LB_OP:  ext_data = {{24{result_q[7]}}, result_q[7:0]};
      `EX_LH_OP:  ext_data = {{16{result_q[15]}}, result_q[15:0]};
      `EX_LBU_OP: ext_data = {24'd0, result_q[7:0]};
      `EX_LHU_OP: ext_data = {16'd0, result_q[15:0]};
      default:    ext_data = result_q;
    endcase
  end

  // Writeback and stall are gated by reset so they drop without a clock edge.
  always_comb begin
    w_enable_o      = 1'b0;
    w_addr_o        = 5'd0;
    w_data_o        = 32'd0;
    mem_stall_req_o = 1'b0;
    if (rst) begin
      case (state_q)
        S_IDLE: begin
          if (is_mem_op(aluop_i)) begin
            mem_stall_req_o = 1'b1;
          end else begin
            w_enable_o = w_enable_i;
            w_addr_o   = w_addr_i;
            w_data_o   = w_data_i;
          end
        end
        S_ACCESS: mem_stall_req_o = 1'b1;
        S_DONE: begin
          if (!is_store(op_q)) begin
            w_enable_o = w_enable_i;
            w_addr_o   = w_addr_i;
            w_data_o   = ext_data;
          end
        end
        default: mem_stall_req_o = 1'b0;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire
